uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_baud_gen.sv | 32 +++
 rtl/uart_tx_fifo.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART transmitter.
//   uart_state_t : transmitter FSM state encoding
//   PAR_NONE / PAR_ODD / PAR_EVEN : values of the PARITY parameter
// Optional feature macro: UART_TX_PARITY_EN adds the PARITY state.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_PARITY = 3'd4
    } uart_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;
`endif

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen -- bit-time divider.
//   clk, rst : clock, asynchronous active-high reset
//   restart  : reload the divider (asserted on the edge a state is entered)
//   tick     : high in the last clock of each CDIV-clock bit time
module uart_baud_gen #(
    parameter int CDIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = $clog2(CDIV);
    localparam logic [CW-1:0] RELOAD = CW'(CDIV - 1);

    logic [CW-1:0] cnt;

    // Down-counter: loaded with CDIV-1 on restart, terminal count at zero,
    // so a restart followed by no further restarts yields tick CDIV clocks later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (restart || cnt == '0)
            cnt <= RELOAD;
        else
            cnt <= cnt - 1'b1;
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- UART transmitter with input FIFO.
//   clk, rst : clock, asynchronous active-high reset
//   data     : DATA_BITS word to queue, accepted when valid && ready
//   valid    : data is offered
//   ready    : FIFO not full
//   tx       : serial line, idle high, registered
//   busy     : a frame is in progress
//   level    : FIFO occupancy
// Optional feature macro: UART_TX_PARITY_EN enables the parity bit
// (PARITY: 0 none, 1 odd, 2 even); without it PARITY is ignored.
//
// state     | meaning
// ----------+----------------------------------------------
// ST_IDLE   | line high, waiting for a FIFO entry
// ST_START  | start bit (0), one bit time
// ST_DATA   | DATA_BITS data bits, LSB first
// ST_PARITY | parity bit (only with UART_TX_PARITY_EN)
// ST_STOP   | STOP_BITS stop bits (1)
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CDIV        = 10,
    parameter int BUFFER_SIZE = 4,
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1,
    parameter int PARITY      = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_BITS-1:0]         data,
    input  logic                         valid,
    output logic                         ready,
    output logic                         tx,
    output logic                         busy,
    output logic [$clog2(BUFFER_SIZE):0] level
);

    localparam int AW = $clog2(BUFFER_SIZE);
    localparam int LW = AW + 1;
    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    if (CDIV < 2 || BUFFER_SIZE < 2 || (BUFFER_SIZE & (BUFFER_SIZE - 1)) != 0 ||
        DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 8 ||
        PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_params
        $error("uart_tx_fifo: parameter out of range");
    end

    // FIFO
    logic [DATA_BITS-1:0] mem [BUFFER_SIZE];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic                 push, pop, empty;
    logic [DATA_BITS-1:0] head;

    assign ready = (level != LW'(BUFFER_SIZE));
    assign push  = valid && ready;
    assign empty = (level == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= data;
    end

    // Pointers wrap naturally because BUFFER_SIZE is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                level <= level + 1'b1;
            else if (pop && !push)
                level <= level - 1'b1;
        end
    end

    // Transmitter
    uart_state_t          state, state_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic [2:0]           bit_cnt, bit_cnt_nxt;
    logic                 tx_nxt, restart, tick, load;

    uart_baud_gen #(.CDIV(CDIV)) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_ON = (PARITY != PAR_NONE);
    logic par_bit, par_nxt;
`endif

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        restart     = 1'b0;
        load        = 1'b0;
        pop         = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_nxt     = par_bit;
`endif
        case (state)
            ST_IDLE:
                load = !empty;
            ST_START:
                if (tick) begin
                    state_nxt   = ST_DATA;
                    bit_cnt_nxt = '0;
                    restart     = 1'b1;
                end
            ST_DATA:
                if (tick) begin
                    if (bit_cnt == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = PAR_ON ? ST_PARITY : ST_STOP;
`else
                        state_nxt = ST_STOP;
`endif
                        bit_cnt_nxt = '0;
                        restart     = 1'b1;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                        shreg_nxt   = shreg >> 1;
                    end
                end
`ifdef UART_TX_PARITY_EN
            ST_PARITY:
                if (tick) begin
                    state_nxt   = ST_STOP;
                    bit_cnt_nxt = '0;
                    restart     = 1'b1;
                end
`endif
            ST_STOP:
                if (tick) begin
                    if (bit_cnt == LAST_STOP) begin
                        if (!empty) begin
                            load = 1'b1;
                        end else begin
                            state_nxt = ST_IDLE;
                            restart   = 1'b1;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end
            default:
                state_nxt = ST_IDLE;
        endcase

        // Pop the head straight into the shifter and start a new frame.
        if (load) begin
            pop       = 1'b1;
            shreg_nxt = head;
            state_nxt = ST_START;
            restart   = 1'b1;
`ifdef UART_TX_PARITY_EN
            par_nxt   = (PARITY == PAR_ODD) ? ~^head : ^head;
`endif
        end

        // tx is registered, so it is derived from the next state.
        case (state_nxt)
            ST_START:  tx_nxt = 1'b0;
            ST_DATA:   tx_nxt = shreg_nxt[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_nxt = par_nxt;
`endif
            default:   tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
            tx      <= tx_nxt;
`ifdef UART_TX_PARITY_EN
            par_bit <= par_nxt;
`endif
        end
    end

    assign busy = (state != ST_IDLE);

endmodule
